// File: rtl/timer_bank.sv
// timer_bank: NUM_TIMERS independent countdown channels behind one bus window.
// Ports: clk, rst (sync, active-high), sel/addr/write_enable/write_data bus
// slave, read_result (combinational), irq (pending & IM) per channel, irq_any.
module timer_bank #(
  parameter int NUM_TIMERS = 2,
  parameter int COUNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic [31:0]           addr,
  input  logic                  write_enable,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_result,
  output logic [NUM_TIMERS-1:0] irq,
  output logic                  irq_any
);

  localparam int CH_W =
    (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CNT    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  logic [CH_W-1:0] ch;
  logic [1:0]      rsel;
  logic            ch_ok;
  logic            wr;

  assign ch    = addr[4+CH_W-1:4];
  assign rsel  = addr[3:2];
  assign ch_ok = {{(32-CH_W){1'b0}}, ch} < 32'(NUM_TIMERS);
  assign wr    = sel & write_enable & ch_ok;

  logic [NUM_TIMERS-1:0]              en_v;
  logic [NUM_TIMERS-1:0]              im_v;
  logic [NUM_TIMERS-1:0]              pend_v;
  logic [NUM_TIMERS-1:0][1:0]         mode_v;
  logic [NUM_TIMERS-1:0][COUNT_W-1:0] preset_v;
  logic [NUM_TIMERS-1:0][COUNT_W-1:0] count_v;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    logic               hit;
    logic               wr_ctrl;
    logic               wr_preset;
    logic               wr_status;
    logic               en_nxt;
    state_t             state;
    logic               en;
    logic               im;
    logic               pending;
    logic [1:0]         mode;
    logic [COUNT_W-1:0] preset;
    logic [COUNT_W-1:0] count;

    assign hit       = wr && (ch == CH_W'(i));
    assign wr_ctrl   = hit && (rsel == 2'd0);
    assign wr_preset = hit && (rsel == 2'd1);
    assign wr_status = hit && (rsel == 2'd3);
    // EN as it will be after this edge; a CPU write overrides the
    // hardware clear and decides whether auto-reload continues.
    assign en_nxt    = wr_ctrl ? write_data[0] : en;

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        en      <= 1'b0;
        im      <= 1'b0;
        pending <= 1'b0;
        mode    <= 2'b00;
        preset  <= '0;
        count   <= '0;
      end else begin
        if (wr_ctrl) begin
          en   <= write_data[0];
          mode <= write_data[2:1];
          im   <= write_data[3];
        end
        if (wr_preset)
          preset <= write_data[COUNT_W-1:0];
        if (wr_status && write_data[0])
          pending <= 1'b0;
        unique case (state)
          IDLE: begin
            if (en) begin
              count <= preset;
              state <= CNT;
            end
          end
          CNT: begin
            if (!en) begin
              state <= IDLE;
            end else if (count <= COUNT_W'(1)) begin
              // also catches PRESET=0, so no wrap
              count <= '0;
              state <= EXPIRE;
            end else begin
              count <= count - COUNT_W'(1);
            end
          end
          EXPIRE: begin
            pending <= 1'b1;
            if (mode == 2'b01 && en_nxt) begin
              count <= preset;
              state <= CNT;
            end else begin
              state <= IDLE;
              if (!wr_ctrl)
                en <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign en_v[i]     = en;
    assign im_v[i]     = im;
    assign pend_v[i]   = pending;
    assign mode_v[i]   = mode;
    assign preset_v[i] = preset;
    assign count_v[i]  = count;
  end

  always_comb begin
    read_result = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (sel && ch_ok && ch == CH_W'(i)) begin
        unique case (1'b1)
          rsel == 2'd0:
            read_result = {28'b0, im_v[i], mode_v[i], en_v[i]};
          rsel == 2'd1:
            read_result = 32'(preset_v[i]);
          rsel == 2'd2:
            read_result = 32'(count_v[i]);
          rsel == 2'd3:
            read_result = {31'b0, pend_v[i]};
        endcase
      end
    end
  end

  assign irq     = pend_v & im_v;
  assign irq_any = |irq;

  logic unused_bits;
  assign unused_bits = ^{addr, write_data};

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed bench for timer_bank (3 channels, 8-bit counters).
// Register table plus hand sequences for multi-cycle timing corners.
module tb_timer_bank;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic [2:0]  irq;
  logic        irq_any;

  int vectors = 0;
  int fails   = 0;

  timer_bank #(
    .NUM_TIMERS(3),
    .COUNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .addr        (addr),
    .write_enable(write_enable),
    .write_data  (write_data),
    .read_result (read_result),
    .irq         (irq),
    .irq_any     (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    bit          s;
    int          ch;
    int          rg;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_s(input bit s, input int c, input int r,
                      input logic [31:0] d);
    sel = s;
    write_enable = 1'b1;
    addr = 32'(c * 16 + r * 4);
    write_data = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    wr_s(1'b1, c, r, d);
  endtask

  task automatic rd_s(input bit s, input int c, input int r,
                      output logic [31:0] d);
    sel = s;
    write_enable = 1'b0;
    addr = 32'(c * 16 + r * 4);
    #1;
    d = read_result;
    sel = 1'b0;
  endtask

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic chk_rd(input string n, input int c, input int r,
                        input logic [31:0] exp);
    logic [31:0] v;
    rd_s(1'b1, c, r, v);
    chk(n, v, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // wr, sel, ch, reg, data, expected, name
    tbl.push_back('{0, 1, 0, 0, 0, 0, "rst_c0_ctrl"});
    tbl.push_back('{0, 1, 0, 1, 0, 0, "rst_c0_preset"});
    tbl.push_back('{0, 1, 0, 2, 0, 0, "rst_c0_count"});
    tbl.push_back('{0, 1, 0, 3, 0, 0, "rst_c0_status"});
    tbl.push_back('{0, 1, 1, 0, 0, 0, "rst_c1_ctrl"});
    tbl.push_back('{0, 1, 1, 1, 0, 0, "rst_c1_preset"});
    tbl.push_back('{0, 1, 1, 2, 0, 0, "rst_c1_count"});
    tbl.push_back('{0, 1, 1, 3, 0, 0, "rst_c1_status"});
    tbl.push_back('{0, 1, 2, 1, 0, 0, "rst_c2_preset"});
    tbl.push_back('{1, 1, 2, 1, 32'h1FF, 0, "w_c2_preset"});
    tbl.push_back('{0, 1, 2, 1, 0, 32'hFF, "trunc_preset"});
    tbl.push_back('{1, 1, 2, 2, 32'h55, 0, "w_c2_count"});
    tbl.push_back('{0, 1, 2, 2, 0, 0, "count_ro"});
    tbl.push_back('{1, 1, 3, 1, 32'h77, 0, "w_c3_preset"});
    tbl.push_back('{0, 1, 3, 1, 0, 0, "c3_preset"});
    tbl.push_back('{0, 1, 3, 0, 0, 0, "c3_ctrl"});
    tbl.push_back('{1, 1, 2, 0, 32'hFFFFFFF6, 0, "w_c2_ctrl"});
    tbl.push_back('{0, 1, 2, 0, 0, 32'h6, "ctrl_upper0"});
    tbl.push_back('{1, 1, 2, 0, 32'h0, 0, "w_c2_ctrl0"});
    tbl.push_back('{1, 0, 2, 1, 32'h33, 0, "w_nosel"});
    tbl.push_back('{0, 1, 2, 1, 0, 32'hFF, "nosel_write"});
    tbl.push_back('{0, 0, 2, 1, 0, 0, "nosel_read"});
    tbl.push_back('{0, 1, 0, 1, 0, 0, "c3_alias"});

    rst = 1'b1;
    sel = 1'b1;
    write_enable = 1'b1;
    addr = 32'h0;
    write_data = 32'hFFFF_FFFF;
    tick(2);
    rst = 1'b0;
    sel = 1'b0;
    write_enable = 1'b0;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_irq_any", 32'(irq_any), 0);

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        wr_s(tbl[i].s, tbl[i].ch, tbl[i].rg, tbl[i].data);
      end else begin
        logic [31:0] v;
        rd_s(tbl[i].s, tbl[i].ch, tbl[i].rg, v);
        chk(tbl[i].name, v, tbl[i].exp);
        tick(1);
      end
    end

    // one-shot, ch0, P=3
    wr(0, 1, 3);
    wr(0, 0, 32'b1001);
    chk_rd("os_idle_count", 0, 2, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk_rd("os_count", 0, 2, 32'(4 - k));
      chk("os_irq_low", 32'(irq), 0);
    end
    tick(1);
    chk("os_irq", 32'(irq), 32'b001);
    chk("os_irq_any", 32'(irq_any), 1);
    chk_rd("os_ctrl", 0, 0, 32'b1000);
    chk_rd("os_status", 0, 3, 1);
    tick(2);
    chk_rd("os_count_hold", 0, 2, 0);
    wr(0, 3, 0);
    chk_rd("os_w0_status", 0, 3, 1);
    wr(0, 3, 1);
    chk_rd("os_clr_status", 0, 3, 0);
    chk("os_clr_irq", 32'(irq), 0);

    // auto-reload, ch1, P=2
    wr(1, 1, 2);
    wr(1, 0, 32'b1011);
    chk_rd("ar_ctrl", 1, 0, 32'hB);
    tick(3);
    chk_rd("ar_exp_nopend", 1, 3, 0);
    tick(1);
    chk_rd("ar_pend1", 1, 3, 1);
    chk_rd("ar_reload", 1, 2, 2);
    wr(1, 3, 1);
    chk_rd("ar_clr", 1, 3, 0);
    chk_rd("ar_cnt1", 1, 2, 1);
    tick(1);
    chk_rd("ar_exp2_nopend", 1, 3, 0);
    wr(1, 3, 1);
    chk_rd("ar_set_wins", 1, 3, 1);
    chk_rd("ar_reload2", 1, 2, 2);
    wr(1, 3, 1);
    chk_rd("ar_clr2", 1, 3, 0);
    chk("ar_irq_low", 32'(irq), 0);
    tick(1);
    wr(1, 0, 32'b1010);
    chk_rd("ar_en0_pend", 1, 3, 1);
    chk("ar_en0_irq", 32'(irq), 32'b010);
    chk_rd("ar_en0_ctrl", 1, 0, 32'hA);
    tick(3);
    chk_rd("ar_en0_idle", 1, 2, 0);
    chk_rd("ar_sticky", 1, 3, 1);
    wr(1, 3, 1);
    chk_rd("ar_clr3", 1, 3, 0);

    // CPU EN write beats hardware clear, ch2, P=1
    wr(2, 1, 1);
    wr(2, 0, 32'b0001);
    tick(1);
    chk_rd("cw_count", 2, 2, 1);
    tick(1);
    wr(2, 0, 32'b0001);
    chk_rd("cw_ctrl", 2, 0, 1);
    chk_rd("cw_status", 2, 3, 1);
    chk_rd("cw_idle", 2, 2, 0);
    tick(1);
    chk_rd("cw_restart", 2, 2, 1);
    wr(2, 0, 0);
    tick(3);

    // mask/independence; ch0 P=0 times like P=1
    wr(0, 1, 0);
    wr(1, 1, 1);
    wr(0, 0, 32'b0001);
    wr(1, 0, 32'b1001);
    tick(1);
    chk_rd("p0_nopend", 0, 3, 0);
    tick(1);
    chk_rd("p0_pend", 0, 3, 1);
    chk("mask_irq0", 32'(irq), 0);
    tick(1);
    chk("mask_irq", 32'(irq), 32'b010);
    chk("mask_irq_any", 32'(irq_any), 1);
    chk_rd("mask_c0_status", 0, 3, 1);
    wr(0, 0, 32'b1000);
    chk("unmask_irq", 32'(irq), 32'b011);
    wr(0, 3, 1);
    wr(1, 3, 1);
    chk("mask_clr_irq", 32'(irq), 0);
    chk("mask_clr_any", 32'(irq_any), 0);

    // pause/resume, ch0, P=10
    wr(0, 1, 10);
    wr(0, 0, 32'b0001);
    tick(4);
    chk_rd("pr_count7", 0, 2, 7);
    wr(0, 0, 0);
    chk_rd("pr_count6", 0, 2, 6);
    tick(3);
    chk_rd("pr_hold", 0, 2, 6);
    wr(0, 0, 32'b0001);
    chk_rd("pr_resume_hold", 0, 2, 6);
    tick(1);
    chk_rd("pr_reload", 0, 2, 10);
    wr(0, 1, 20);
    chk_rd("pr_mid_preset", 0, 2, 9);
    chk_rd("pr_preset", 0, 1, 20);
    tick(1);
    chk_rd("pr_count8", 0, 2, 8);

    // reset mid-count
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_rd("mr_count", 0, 2, 0);
    chk_rd("mr_preset", 0, 1, 0);
    chk_rd("mr_ctrl", 0, 0, 0);
    chk_rd("mr_c2_status", 2, 3, 0);
    chk("mr_irq", 32'(irq), 0);
    tick(2);
    chk_rd("mr_idle", 0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel countdown timer: the next generation of the single `timer` peripheral, which the `mips` top instantiates twice behind `bridge`. One `timer_bank` replaces both instances. It occupies one bridge device window, holds NUM_TIMERS independent channels, and adds auto-reload mode, per-channel interrupt masking and write-1-to-clear interrupt status. Per-channel interrupt lines feed `hwirq`.

## Interface
- NUM_TIMERS, default 2, channel count, legal range 1..8
- COUNT_W, default 32, counter/preset width, legal range 1..32
- clk  in  1  system clock
- rst  in  1  reset; one clock domain, synchronous, active-high
- sel  in  1  device select from `bridge` (window hit)
- addr  in  32  byte address; [3:2] register, [4+CH_W-1:4] channel, CH_W = max(1, clog2(NUM_TIMERS)); other bits ignored
- write_enable  in  1  write strobe, effective only when sel=1
- write_data  in  32  write data
- read_result  out  32  combinational read data
- irq  out  NUM_TIMERS  per-channel interrupt, = pending & IM
- irq_any  out  1  OR of irq

## Operation
- Per-channel registers:
  - CTRL (reg 0): bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x reserved and treated as one-shot), bit3 IM; bits 31:4 read 0.
  - PRESET (reg 1): COUNT_W bits; upper write bits dropped.
  - COUNT (reg 2): read-only; writes ignored.
  - STATUS (reg 3): bit0 PENDING; writing 1 to bit0 clears it, writing 0 has no effect.
- Reads zero-extend to 32 bits. Reads return 0 when sel=0 or the channel index is ≥ NUM_TIMERS; writes to such a channel are ignored.
- Per-channel FSM, 3 states: IDLE, CNT, EXPIRE.
  - IDLE: if EN=1 at an edge, COUNT←PRESET and go to CNT. COUNT holds otherwise.
  - CNT: if EN=0, go to IDLE with COUNT holding. Else if COUNT ≤ 1, COUNT←0 and go to EXPIRE. Else COUNT←COUNT−1.
  - EXPIRE: PENDING←1. In one-shot mode, EN←0 and go to IDLE. In auto-reload mode, COUNT←PRESET and go to CNT.
- Writing CTRL with EN=1 while in CNT does not restart the count. MODE/IM changes take effect immediately; a MODE change affects the next EXPIRE.
- Writing PRESET mid-count affects only the next load.
- Channels are fully independent; at most one bus write per cycle.

## Timing
- Reset: all CTRL, PRESET, COUNT, PENDING = 0; every FSM in IDLE. Consequently irq = 0, irq_any = 0, and read_result = 0 for any selected address.
- Reset has priority over everything, including mid-count and any write in the same cycle.
- Register writes commit at the clock edge. read_result reflects the new value in the following cycle; there is no read latency.
- One-shot mode, PRESET=P ≥ 1, EN written at edge E0:
  - E1: COUNT = P.
  - E1+P: COUNT = 0, FSM in EXPIRE.
  - E2+P: PENDING = 1, irq high if IM = 1.
  - irq therefore rises P+2 cycles after the enabling write.
- PRESET = 0 behaves exactly as PRESET = 1.
- Auto-reload: EXPIRE recurs every P+1 cycles. PENDING stays set (sticky) until cleared.
- Same-edge conflicts:
  - STATUS clear vs EXPIRE setting PENDING: set wins.
  - CPU CTRL write vs one-shot hardware EN clear: CPU write wins, and the FSM still goes to IDLE.
  - EN=0 write in the same cycle the FSM is in EXPIRE: PENDING is still set, FSM goes to IDLE.
- COUNT_W < 32: the decrement never wraps, because the ≤1 check stops at 0.

## Test plan
- Reset: drive rst for 2 cycles with write_enable=1 and sel=1 -> CTRL/PRESET/COUNT/STATUS of all channels read 0; irq = 0.
- One-shot: ch0 PRESET=3, CTRL=0b1001 -> COUNT reads 3,2,1,0 on successive cycles; irq[0] rises 5 cycles after the CTRL write; CTRL reads 0b1000; COUNT stays 0.
- Auto-reload: ch1 PRESET=2, CTRL=0b1011 -> PENDING every 3 cycles; write STATUS=1 on the exact EXPIRE-set edge -> PENDING remains 1; a clear on a later cycle -> PENDING 0, irq[1] low.
- Mask/independence: ch0 IM=0, ch1 IM=1, both expire -> irq = 2'b10, irq_any = 1, ch0 STATUS = 1.
- Pause/resume: ch0 PRESET=10, EN=0 written when COUNT=6 -> COUNT holds 6. EN=1 written -> COUNT reloads to 10 on the next edge (IDLE path). PRESET written mid-count -> current count unaffected.
- Boundary: NUM_TIMERS=3, COUNT_W=8, access channel 3 -> read 0, writes ignored. PRESET=0x1FF -> reads 0xFF. PRESET=0 expires with the same timing as PRESET=1. rst asserted mid-count -> all state 0 next cycle.
